tts_controller_poller: RTL and testbench
========================================

// Module: tts_controller_poller
// PURPOSE
//  Parametrised NES/SNES controller poller for Tiny Tapestation: the successor to the fixed single-pad reader.
//  Drives one shared latch/clock pair to N_PORTS pads and shifts in each pad's serial data in parallel.
//  Publishes debounced-optional, active-high button words with per-button press edges and connect status.
//  Sits between the controller pins (ui_in/uio_out) and the game logic.
// PARAMETERS
//  N_PORTS      2          number of pads sharing CTRL_LATCH/CTRL_CLK (1..4)
//  SNES_MODE    1          1: 16 bits per transaction; 0: NES, 8 bits
//  CLK_DIV      600        CLK cycles per CTRL_CLK half-period (>=1); 600 = 6 us at 100 MHz
//  POLL_PERIOD  1666666    CLK cycles between successive latch starts (60 Hz at 100 MHz)
// PORTS
//  CLK        in   1            system clock
//  RST        in   1            synchronous, active-high reset
//  CTRL_DATA  in   N_PORTS      serial data from each pad, active-low (0 = pressed)
//  CTRL_LATCH out  1            pad latch, active-high
//  CTRL_CLK   out  1            pad shift clock, idles high
//  BUTTONS    out  N_PORTS*16   port p in [16p+15:16p], bit k = k-th shifted bit, 1 = pressed
//  PRESSED    out  N_PORTS*16   1-cycle rising-edge flags, asserted with VALID
//  CONNECTED  out  N_PORTS      1 = pad detected on last transaction
//  VALID      out  1            1-cycle pulse when BUTTONS/PRESSED/CONNECTED update
// BEHAVIOUR
//  Reset values: CTRL_LATCH=0, CTRL_CLK=1, BUTTONS=0, PRESSED=0, CONNECTED=0, VALID=0; FSM=IDLE, counters=0.
//  RST mid-transaction aborts immediately; no partial word is ever published.
//  NBITS = SNES_MODE ? 16 : 8. In NES mode bits [16p+15:16p+8] are always 0.
//  FSM: IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
//   IDLE : wait until period counter reaches POLL_PERIOD-1; first latch starts the cycle after RST deasserts.
//   LATCH: CTRL_LATCH=1 for exactly 2*CLK_DIV cycles; period counter restarts at latch start.
//   SHIFT: per bit k=0..NBITS-1: CTRL_CLK=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
//          CTRL_DATA is sampled on the last cycle of each low phase (bit 0 = B/NES A, shifted first).
//   DONE : 1 cycle; all outputs update, VALID=1; then IDLE.
//  Transaction length = 2*CLK_DIV + NBITS*2*CLK_DIV + 1 cycles.
//  If POLL_PERIOD is shorter than that, polls run back-to-back: IDLE is left after 1 cycle.
//  Raw word r = ~samples. CONNECTED[p] = ~(&r_p): all-pressed reads as an unplugged pin with pull-down.
//  When CONNECTED[p]=0, BUTTONS for port p are forced to 0.
//  PRESSED = new_BUTTONS & ~old_BUTTONS, valid only in the VALID cycle, 0 otherwise.
//  Disconnect->connect with buttons held raises PRESSED for those buttons.
//  Ports are independent: one pad unplugged never affects another port's word.
// CONFIGURATION
//  `CTRL_FILTER_EN defined: a port's candidate word is committed to BUTTONS only when two consecutive
//   transactions produce the identical raw word; otherwise BUTTONS/CONNECTED hold and PRESSED=0 for that port.
//   VALID still pulses every DONE.
//   The first transaction after reset only primes the filter, so BUTTONS first change at the 2nd DONE.
//  Not defined: every transaction commits directly; no filter registers are synthesised.
// STRUCTURE
//  Package tts_ctrl_pkg:
//   - state enum (IDLE, LATCH, SHIFT, DONE)
//   - MAX_BITS=16
//   - button index constants BTN_B/Y/SELECT/START/UP/DOWN/LEFT/RIGHT/A/X/L/R (SNES order)
//   - NES index aliases
//  Top: FSM, CLK_DIV counter, bit counter, period counter, pin drivers.
//  Sub-module tts_ctrl_port_shifter, one instance per port: shift register, optional filter,
//   connect detect, edge detect.
// TESTING  (CLK_DIV=2, POLL_PERIOD=100, N_PORTS=2)
//  1. Reset release, SNES: latch high cycles 1-4, 16 CTRL_CLK low pulses of 2 cycles, VALID at cycle 69,
//     next latch at cycle 101.
//  2. Port0 model drives A (bit 8) + START (bit 3) low, port1 idle-high
//     -> BUTTONS=0x0000_0108, PRESSED=0x0000_0108 on 1st VALID, PRESSED=0 on 2nd.
//  3. Port1 data tied 0 -> CONNECTED=2'b01, BUTTONS[31:16]=0; release tie -> CONNECTED=2'b11.
//  4. SNES_MODE=0 -> 8 clock pulses, VALID at cycle 37, upper bytes 0 for any data pattern.
//  5. RST asserted during bit 5 of SHIFT -> next cycle CTRL_CLK=1, CTRL_LATCH=0, outputs 0;
//     new latch starts after release.
//  6. `CTRL_FILTER_EN: single-transaction glitch on UP is never published;
//     a press held 2 polls appears at the 2nd VALID.

Source files
------------

// File: rtl/tts_ctrl_pkg.sv
// Shared types and constants for the Tiny Tapestation NES/SNES controller poller.
// Button indices follow the SNES shift order; NES aliases map onto the same bit positions.
package tts_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    localparam int MAX_BITS = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // An NES pad shifts A first, where an SNES pad shifts B.
    localparam int NES_A      = BTN_B;
    localparam int NES_B      = BTN_Y;
    localparam int NES_SELECT = BTN_SELECT;
    localparam int NES_START  = BTN_START;
    localparam int NES_UP     = BTN_UP;
    localparam int NES_DOWN   = BTN_DOWN;
    localparam int NES_LEFT   = BTN_LEFT;
    localparam int NES_RIGHT  = BTN_RIGHT;

    function automatic int nbits_for(input int snes_mode);
        return (snes_mode != 0) ? MAX_BITS : 8;
    endfunction

endpackage

// File: rtl/tts_ctrl_port_shifter.sv
// Per-pad capture: assembles one transaction's raw word, detects connection and press edges.
// Optional two-transaction stability filter selected by `CTRL_FILTER_EN.
module tts_ctrl_port_shifter
    import tts_ctrl_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                sample,
    input  logic [3:0]          bit_idx,
    input  logic                data,
    input  logic                commit,
    output logic [MAX_BITS-1:0] buttons,
    output logic [MAX_BITS-1:0] pressed,
    output logic                connected
);

    localparam logic [MAX_BITS-1:0] MASK = MAX_BITS'((32'd1 << NBITS) - 32'd1);

    logic [MAX_BITS-1:0] raw;
    logic [MAX_BITS-1:0] btn_new;
    logic                conn_new;
    logic                take;

    // Pads are active-low; the word is cleared at latch start so NES upper bits stay 0.
    always_ff @(posedge CLK) begin
        if (clear) begin
            raw <= '0;
        end else if (sample) begin
            raw[bit_idx] <= ~data;
        end
    end

    // A floating pin pulled low reads as every button held: treat that as unplugged.
    assign conn_new = ~(&(raw | ~MASK));
    assign btn_new  = conn_new ? (raw & MASK) : '0;

`ifdef CTRL_FILTER_EN
    logic [MAX_BITS-1:0] prev_raw;
    logic                primed;

    always_ff @(posedge CLK) begin
        if (commit) begin
            prev_raw <= raw;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            primed <= 1'b0;
        end else if (commit) begin
            primed <= 1'b1;
        end
    end

    assign take = primed && (raw == prev_raw);
`else
    assign take = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            buttons   <= '0;
            pressed   <= '0;
            connected <= 1'b0;
        end else begin
            pressed <= '0;
            if (commit && take) begin
                buttons   <= btn_new;
                pressed   <= btn_new & ~buttons;
                connected <= conn_new;
            end
        end
    end

endmodule

// File: rtl/tts_controller_poller.sv
// NES/SNES multi-pad poller: drives the shared latch/clock and publishes per-port button words.
// Define CTRL_FILTER_EN to require two identical consecutive reads before a word is committed.
module tts_controller_poller
    import tts_ctrl_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int SNES_MODE   = 1,
    parameter int CLK_DIV     = 600,
    parameter int POLL_PERIOD = 1666666
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_PORTS-1:0]      CTRL_DATA,
    output logic                    CTRL_LATCH,
    output logic                    CTRL_CLK,
    output logic [N_PORTS*16-1:0]   BUTTONS,
    output logic [N_PORTS*16-1:0]   PRESSED,
    output logic [N_PORTS-1:0]      CONNECTED,
    output logic                    VALID
);

    localparam int NBITS = nbits_for(SNES_MODE);
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int PER_W = $clog2(POLL_PERIOD + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LATCH = ST_LATCH;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD - 1);
    localparam logic [3:0]       BIT_LAST   = 4'(NBITS - 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [PER_W-1:0] per_cnt;
    logic             clk_high;
    logic             first_poll;

    logic             go;
    logic             half_end;
    logic             sample;
    logic             commit;

    assign go       = (state == S_IDLE) && (first_poll || (per_cnt == PER_LAST));
    assign half_end = (state == S_SHIFT) && (div_cnt == HALF_LAST);
    assign sample   = half_end && !clk_high;
    // Commit on the edge into DONE so the outputs are already fresh while VALID is high.
    assign commit   = half_end && clk_high && (bit_cnt == BIT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            clk_high   <= 1'b0;
            first_poll <= 1'b1;
        end else begin
            // Saturating, so a short POLL_PERIOD simply yields back-to-back polls.
            if (per_cnt != PER_LAST) begin
                per_cnt <= per_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state      <= S_LATCH;
                        div_cnt    <= '0;
                        per_cnt    <= '0;
                        first_poll <= 1'b0;
                    end
                end
                S_LATCH: begin
                    if (div_cnt == LATCH_LAST) begin
                        state    <= S_SHIFT;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        clk_high <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        div_cnt  <= '0;
                        clk_high <= ~clk_high;
                        if (clk_high) begin
                            if (bit_cnt == BIT_LAST) begin
                                state <= S_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign CTRL_LATCH = (state == S_LATCH);
    assign CTRL_CLK   = !((state == S_SHIFT) && !clk_high);
    assign VALID      = (state == S_DONE);

    genvar p;
    generate
        for (p = 0; p < N_PORTS; p++) begin : g_port
            tts_ctrl_port_shifter #(
                .NBITS (NBITS)
            ) u_shifter (
                .CLK       (CLK),
                .RST       (RST),
                .clear     (go),
                .sample    (sample),
                .bit_idx   (bit_cnt),
                .data      (CTRL_DATA[p]),
                .commit    (commit),
                .buttons   (BUTTONS[16*p +: 16]),
                .pressed   (PRESSED[16*p +: 16]),
                .connected (CONNECTED[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tts_controller_poller.sv
// Directed bench for tts_controller_poller: one SNES and one NES instance with behavioural pad models.
module tb_tts_controller_poller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  data_s, data_n;
    logic        latch_s, clkp_s, valid_s;
    logic        latch_n, clkp_n, valid_n;
    logic [31:0] btn_s, prs_s, btn_n, prs_n;
    logic [1:0]  conn_s, conn_n;

    logic [15:0] pmask_s [2];
    logic [15:0] pmask_n [2];
    logic [1:0]  tie_s = 2'b00;
    logic [4:0]  idx_s = '0;
    logic [4:0]  idx_n = '0;
    logic        clk_s_q = 1'b1;
    logic        clk_n_q = 1'b1;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    tts_controller_poller #(
        .N_PORTS(2), .SNES_MODE(1), .CLK_DIV(2), .POLL_PERIOD(100)
    ) u_snes (
        .CLK(clk), .RST(rst), .CTRL_DATA(data_s), .CTRL_LATCH(latch_s), .CTRL_CLK(clkp_s),
        .BUTTONS(btn_s), .PRESSED(prs_s), .CONNECTED(conn_s), .VALID(valid_s)
    );

    tts_controller_poller #(
        .N_PORTS(2), .SNES_MODE(0), .CLK_DIV(2), .POLL_PERIOD(100)
    ) u_nes (
        .CLK(clk), .RST(rst), .CTRL_DATA(data_n), .CTRL_LATCH(latch_n), .CTRL_CLK(clkp_n),
        .BUTTONS(btn_n), .PRESSED(prs_n), .CONNECTED(conn_n), .VALID(valid_n)
    );

    // Pad model: latch reloads the shifter, each CTRL_CLK rising edge advances one bit.
    always @(posedge clk) begin
        clk_s_q <= clkp_s;
        clk_n_q <= clkp_n;
        if (latch_s) idx_s <= '0;
        else if (!clk_s_q && clkp_s && idx_s < 5'd16) idx_s <= idx_s + 5'd1;
        if (latch_n) idx_n <= '0;
        else if (!clk_n_q && clkp_n && idx_n < 5'd16) idx_n <= idx_n + 5'd1;
    end

    always_comb begin
        data_s = 2'b00;
        data_n = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (!tie_s[p] && idx_s < 5'd16) data_s[p] = ~pmask_s[p][idx_s[3:0]];
            if (idx_n < 5'd16) data_n[p] = ~pmask_n[p][idx_n[3:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (valid_s) ok = 1'b1;
        end
        chk({tag, "_valid_seen"}, 64'(ok), 64'd1);
    endtask

    initial begin
        int pulses_s, pulses_n, lat0;
        logic prev_s, prev_n;
        logic exp_latch, exp_clk_s, exp_clk_n;

        pmask_s[0] = 16'h0108;   // A + START
        pmask_s[1] = 16'h0000;
        pmask_n[0] = 16'hAA55;   // upper byte must never appear in NES mode
        pmask_n[1] = 16'hFF00;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_latch", 64'(latch_s), 64'd0);
        chk("rst_clk", 64'(clkp_s), 64'd1);
        chk("rst_buttons", 64'(btn_s), 64'd0);
        chk("rst_pressed", 64'(prs_s), 64'd0);
        chk("rst_connected", 64'(conn_s), 64'd0);
        chk("rst_valid", 64'(valid_s), 64'd0);

        // Cycle 0 is the first cycle with RST low.
        rst = 1'b0;
        cyc = 0;
        pulses_s = 0;
        pulses_n = 0;
        prev_s = clkp_s;
        prev_n = clkp_n;
        for (int c = 1; c <= 101; c++) begin
            tick();
            exp_latch = (c >= 1 && c <= 4) || (c == 101);
            exp_clk_s = !(c >= 5 && c <= 68 && ((c - 5) % 4) < 2);
            exp_clk_n = !(c >= 5 && c <= 36 && ((c - 5) % 4) < 2);
            chk($sformatf("snes_latch_c%0d", c), 64'(latch_s), 64'(exp_latch));
            chk($sformatf("snes_clk_c%0d", c), 64'(clkp_s), 64'(exp_clk_s));
            chk($sformatf("snes_valid_c%0d", c), 64'(valid_s), 64'(c == 69));
            chk($sformatf("nes_latch_c%0d", c), 64'(latch_n), 64'(exp_latch));
            chk($sformatf("nes_clk_c%0d", c), 64'(clkp_n), 64'(exp_clk_n));
            chk($sformatf("nes_valid_c%0d", c), 64'(valid_n), 64'(c == 37));
            if (prev_s && !clkp_s) pulses_s++;
            if (prev_n && !clkp_n) pulses_n++;
            prev_s = clkp_s;
            prev_n = clkp_n;
`ifdef CTRL_FILTER_EN
            if (c == 69) chk("flt_prime_buttons", 64'(btn_s), 64'd0);
`else
            if (c == 69) begin
                chk("t2_buttons", 64'(btn_s), 64'h0000_0108);
                chk("t2_pressed", 64'(prs_s), 64'h0000_0108);
                chk("t2_connected", 64'(conn_s), 64'h3);
            end
            if (c == 37) begin
                chk("nes_buttons", 64'(btn_n), 64'h0000_0055);
                chk("nes_pressed", 64'(prs_n), 64'h0000_0055);
                chk("nes_connected", 64'(conn_n), 64'h3);
            end
`endif
        end
        chk("snes_pulses", 64'(pulses_s), 64'd16);
        chk("nes_pulses", 64'(pulses_n), 64'd8);

`ifdef CTRL_FILTER_EN
        wait_valid("flt_t2");
        chk("flt_t2_buttons", 64'(btn_s), 64'h0000_0108);
        chk("flt_t2_pressed", 64'(prs_s), 64'h0000_0108);
        pmask_s[0] = 16'h0118;   // UP glitch for a single poll
        wait_valid("flt_t3");
        chk("flt_glitch_buttons", 64'(btn_s), 64'h0000_0108);
        chk("flt_glitch_pressed", 64'(prs_s), 64'h0);
        pmask_s[0] = 16'h0108;
        wait_valid("flt_t4");
        chk("flt_after_glitch", 64'(btn_s), 64'h0000_0108);
        wait_valid("flt_t5");
        chk("flt_settled", 64'(btn_s), 64'h0000_0108);
        pmask_s[0] = 16'h0128;   // DOWN held for two polls
        wait_valid("flt_t6");
        chk("flt_hold1_buttons", 64'(btn_s), 64'h0000_0108);
        chk("flt_hold1_pressed", 64'(prs_s), 64'h0);
        wait_valid("flt_t7");
        chk("flt_hold2_buttons", 64'(btn_s), 64'h0000_0128);
        chk("flt_hold2_pressed", 64'(prs_s), 64'h0000_0020);
`else
        wait_valid("t2b");
        chk("t2b_pressed", 64'(prs_s), 64'h0);
        chk("t2b_buttons", 64'(btn_s), 64'h0000_0108);
        tie_s[1] = 1'b1;
        pmask_s[1] = 16'h0001;
        wait_valid("t3a");
        chk("t3a_connected", 64'(conn_s), 64'h1);
        chk("t3a_buttons", 64'(btn_s), 64'h0000_0108);
        chk("t3a_pressed", 64'(prs_s), 64'h0);
        tie_s[1] = 1'b0;
        wait_valid("t3b");
        chk("t3b_connected", 64'(conn_s), 64'h3);
        chk("t3b_buttons", 64'(btn_s), 64'h0001_0108);
        chk("t3b_pressed", 64'(prs_s), 64'h0001_0000);
`endif

        // Abort in the middle of bit 5 of a transaction.
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick();
                if (latch_s) seen = 1'b1;
            end
            chk("t5_latch_seen", 64'(seen), 64'd1);
        end
        lat0 = cyc;
        repeat (25) tick();
        chk("t5_in_bit5", 64'(cyc - lat0), 64'd25);
        chk("t5_clk_low", 64'(clkp_s), 64'd0);
        rst = 1'b1;
        tick();
        chk("t5_clk", 64'(clkp_s), 64'd1);
        chk("t5_latch", 64'(latch_s), 64'd0);
        chk("t5_buttons", 64'(btn_s), 64'd0);
        chk("t5_pressed", 64'(prs_s), 64'd0);
        chk("t5_connected", 64'(conn_s), 64'd0);
        chk("t5_valid", 64'(valid_s), 64'd0);
        chk("t5_nes_clk", 64'(clkp_n), 64'd1);
        chk("t5_nes_buttons", 64'(btn_n), 64'd0);
        rst = 1'b0;
        tick();
        chk("t5_relatch", 64'(latch_s), 64'd1);
        chk("t5_nes_relatch", 64'(latch_n), 64'd1);
        wait_valid("t5_post");
`ifndef CTRL_FILTER_EN
        chk("t5_post_buttons", 64'(btn_s), 64'h0001_0108);
        chk("t5_post_pressed", 64'(prs_s), 64'h0001_0108);
`else
        chk("t5_post_buttons", 64'(btn_s), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
